// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC phase generator: angle width, pi constants,
// FSM state encoding and the triangular-sweep next-angle function.
package cordic_pkg;

    // Signed Q2.14 radians
    localparam int ANGLE_WIDTH = 16;
    // Accumulator step math width: two guard bits so acc + inc never wraps
    localparam int STEP_WIDTH  = ANGLE_WIDTH + 2;

    localparam logic [ANGLE_WIDTH-1:0] PI_HALF = 16'h6488;
    localparam logic [ANGLE_WIDTH:0]   PI      = 17'h0C910;

    localparam logic signed [STEP_WIDTH-1:0] PI_HALF_X     = 18'sh06488;
    localparam logic signed [STEP_WIDTH-1:0] NEG_PI_HALF_X = -18'sh06488;
    localparam logic signed [STEP_WIDTH-1:0] PI_X          = 18'sh0C910;
    localparam logic signed [STEP_WIDTH-1:0] NEG_PI_X      = -18'sh0C910;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ANGLE_WIDTH-1:0] angle;
        logic                   dir_down;
    } step_t;

    function automatic logic signed [STEP_WIDTH-1:0] sext_angle(
        input logic [ANGLE_WIDTH-1:0] v
    );
        return {{(STEP_WIDTH-ANGLE_WIDTH){v[ANGLE_WIDTH-1]}}, v};
    endfunction

    // Limit a signed starting angle to [-pi/2, +pi/2]
    function automatic logic [ANGLE_WIDTH-1:0] clamp_init(
        input logic [ANGLE_WIDTH-1:0] v
    );
        logic signed [STEP_WIDTH-1:0] x;
        x = sext_angle(v);
        if (x > PI_HALF_X)
            return PI_HALF_X[ANGLE_WIDTH-1:0];
        else if (x < NEG_PI_HALF_X)
            return NEG_PI_HALF_X[ANGLE_WIDTH-1:0];
        else
            return v;
    endfunction

    // Limit an unsigned step magnitude to pi/2
    function automatic logic [ANGLE_WIDTH-1:0] clamp_inc(
        input logic [ANGLE_WIDTH-1:0] v
    );
        return (v > PI_HALF) ? PI_HALF : v;
    endfunction

    // Advance the angle by one step; on crossing +/-pi/2 the overshoot is
    // folded back (x -> +/-pi - x) and the sweep direction flips.
    function automatic step_t next_angle(
        input logic [ANGLE_WIDTH-1:0] acc,
        input logic [ANGLE_WIDTH-1:0] inc,
        input logic                   dir_down
    );
        logic signed [STEP_WIDTH-1:0] a;
        logic signed [STEP_WIDTH-1:0] i;
        logic signed [STEP_WIDTH-1:0] s;
        step_t r;
        a = sext_angle(acc);
        i = {{(STEP_WIDTH-ANGLE_WIDTH){1'b0}}, inc};
        r.dir_down = dir_down;
        if (!dir_down) begin
            s = a + i;
            if (s > PI_HALF_X) begin
                s = PI_X - s;
                r.dir_down = 1'b1;
            end
        end else begin
            s = a - i;
            if (s < NEG_PI_HALF_X) begin
                s = NEG_PI_X - s;
                r.dir_down = 1'b0;
            end
        end
        r.angle = s[ANGLE_WIDTH-1:0];
        return r;
    endfunction

endpackage

// File: rtl/cordic_phase_gen.sv
// Phase sweep generator: emits num_samples angles into a downstream CORDIC
// input FIFO as a triangular sweep bounded by +/-pi/2, stalling on full.
// Ports: clock, reset (sync, active high), start, phase_init, phase_inc,
//        num_samples, full -> busy, done, wr_en, data_out [, stall_count].
// Option: define PHASE_GEN_STALL_COUNT_EN to add the stall_count output,
//         a saturating count of RUN cycles spent blocked by full.
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = ANGLE_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [FIFO_DATA_WIDTH-1:0] phase_init,
    input  logic [FIFO_DATA_WIDTH-1:0] phase_inc,
    input  logic [15:0]                num_samples,
    output logic                       busy,
    output logic                       done,
    output logic                       wr_en,
    output logic [FIFO_DATA_WIDTH-1:0] data_out,
    input  logic                       full
`ifdef PHASE_GEN_STALL_COUNT_EN
    ,
    output logic [15:0]                stall_count
`endif
);

    state_t                 state;
    logic [ANGLE_WIDTH-1:0] acc;
    logic [ANGLE_WIDTH-1:0] inc;
    logic [15:0]            count;
    logic                   dir_down;
    step_t                  step;

    assign step = next_angle(acc, inc, dir_down);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            acc      <= '0;
            inc      <= '0;
            count    <= '0;
            dir_down <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc      <= clamp_init(ANGLE_WIDTH'(phase_init));
                        inc      <= clamp_inc(ANGLE_WIDTH'(phase_inc));
                        count    <= num_samples;
                        dir_down <= 1'b0;
                        state    <= (num_samples == 16'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A write happens exactly when full is low
                    if (!full) begin
                        acc      <= step.angle;
                        dir_down <= step.dir_down;
                        count    <= count - 16'd1;
                        if (count == 16'd1)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PHASE_GEN_STALL_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset)
            stall_count <= '0;
        else if (state == ST_IDLE && start)
            stall_count <= '0;
        else if (state == ST_RUN && full && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif

    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign wr_en    = (state == ST_RUN) && !full;
    assign data_out = FIFO_DATA_WIDTH'($signed(acc));

endmodule
